// File: rtl/gf2mz_unload_if.sv
// Bus bundle for gf2mz_unload: result-memory port plus the coefficient stream.
//   master : the unloader (drives address/write side and stream outputs)
//   slave  : memory model + downstream sink
// Signals:
//   C_di      memory read data, valid one cycle after C_addr
//   C_addr    memory word address
//   C_we/C_do memory write side, unused (tied to 0 by the master)
//   out_valid/out_ready/out_data/out_last  coefficient stream handshake
interface gf2mz_unload_if #(
  parameter int unsigned M     = 83,
  parameter int unsigned Width = 415,
  parameter int unsigned AddrW = 5
);
  logic [Width-1:0] C_di;
  logic [AddrW-1:0] C_addr;
  logic             C_we;
  logic [Width-1:0] C_do;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_data;
  logic             out_last;

  modport master (
    input  C_di, out_ready,
    output C_addr, C_we, C_do, out_valid, out_data, out_last
  );

  modport slave (
    output C_di, out_ready,
    input  C_addr, C_we, C_do, out_valid, out_data, out_last
  );
endinterface

// File: rtl/gf2mz_unload.sv
// Streams a GF(2^m)[z] polynomial out of a packed result memory, one
// coefficient per valid/ready handshake, index 0 first. Each memory word holds
// d coefficients, slot 0 in the most significant m bits.
// Ports:
//   clk, rst_b  clock, asynchronous active-low reset
//   start       begin unloading (ignored unless idle)
//   bus         gf2mz_unload_if.master: memory read port + output stream
//   busy        high whenever not idle
//   done        one-cycle pulse after the final coefficient is accepted
module gf2mz_unload #(
  parameter int unsigned n = 149,
  parameter int unsigned m = 83,
  parameter int unsigned d = 5
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  gf2mz_unload_if.master  bus,
  output logic            busy,
  output logic            done
);
  localparam int unsigned WIDTH = m * d;
  localparam int unsigned DEPTH = (n + d - 1) / d;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = (d > 1) ? $clog2(d) : 1;

  localparam logic [AW-1:0] LastWord = AW'(DEPTH - 1);
  // Slot of coefficient n-1; lower than TopSlot when the final word is partial.
  localparam logic [SW-1:0] LastSlot = SW'((n - 1) % d);
  localparam logic [SW-1:0] TopSlot  = SW'(d - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StEmit, StFin} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    w_q, w_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [SW-1:0]    j_q, j_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [m-1:0]     slot_data;
  logic             is_last;

  always_comb begin
    slot_data = '0;
    for (int s = 0; s < int'(d); s++) begin
      if (j_q == SW'(s)) slot_data = buf_q[WIDTH-1-s*m -: m];
    end
  end

  assign is_last = (w_q == LastWord) && (j_q == LastSlot);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    j_d     = j_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d     = '0;
          j_d     = '0;
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        buf_d   = bus.C_di;
        state_d = StEmit;
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (is_last) begin
            state_d = StFin;
          end else if (j_q == TopSlot) begin
            // Address is registered here so it is already w+1 during FETCH.
            j_d     = '0;
            w_d     = w_q + AW'(1);
            addr_d  = w_q + AW'(1);
            state_d = StFetch;
          end else begin
            j_d = j_q + SW'(1);
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      w_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.C_addr    = addr_q;
  assign bus.C_we      = 1'b0;
  assign bus.C_do      = '0;
  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_data  = (state_q == StEmit) ? slot_data : '0;
  assign bus.out_last  = (state_q == StEmit) && is_last;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFin);
endmodule

// File: doc/gf2mz_unload.md
GF2MZ_UNLOAD -- requirements
Module: gf2mz_unload

Interface
REQ-001 Parameters SHALL be:
- n = 149: number of GF(2^m)[z] coefficients in the polynomial.
- m = 83: bits per GF(2^m) element.
- d = 5: elements per memory word.
- WIDTH = m*d: memory word width.
- DEPTH = ceil(n/d): memory words.
REQ-002 There SHALL be one clock; reset SHALL be asynchronous and active-low; the ports SHALL be named clk and rst_b.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- start  in  1  begin unloading; sampled only in IDLE.
- C_di  in  WIDTH  read data from the result memory; valid one cycle after C_addr.
- C_addr  out  CLOG2(DEPTH)  result-memory word address.
- C_we  out  1  memory write enable; held at 0.
- C_do  out  WIDTH  memory write data; held at 0.
- out_valid  out  1  out_data holds a valid coefficient.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  m  current coefficient.
- out_last  out  1  marks coefficient n-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final transfer.

Function
REQ-004 The block SHALL stream result polynomial C(z) from memory, one coefficient per handshake, in ascending index order 0..n-1.
REQ-005 Coefficient i SHALL reside in word i/d, slot j = i%d, at C_di bits [WIDTH-1-j*m : WIDTH-(j+1)*m]; slot 0 SHALL be the most significant.
REQ-006 The state machine SHALL have states IDLE, FETCH, LATCH, EMIT and FIN.
REQ-007 In IDLE, start=1 SHALL clear the word counter w and the slot counter j, then go to FETCH.
REQ-008 FETCH SHALL drive C_addr=w for one cycle, then go to LATCH.
REQ-009 LATCH SHALL capture C_di into a WIDTH-bit word buffer, then go to EMIT.
REQ-010 In EMIT, out_valid SHALL be 1 and out_data SHALL equal buffer slot j.
REQ-011 A transfer SHALL occur on out_valid & out_ready; without a transfer, out_data and out_last SHALL stay stable.
REQ-012 On a transfer with j<d-1 and index w*d+j<n-1, the block SHALL increment j and remain in EMIT.
REQ-013 On a transfer at j=d-1 with more coefficients remaining, the block SHALL set j=0, increment w and go to FETCH.
REQ-014 On the transfer of index n-1, the block SHALL go to FIN; unused slots of a partial final word SHALL never be emitted.
REQ-015 out_last SHALL be 1 exactly while EMIT presents index n-1.
REQ-016 FIN SHALL assert done for one cycle, then go to IDLE.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 Latency with out_ready held at 1 and start sampled at edge k:
- first out_valid in cycle k+3;
- each full word costs d+2 cycles;
- for default parameters, last transfer in cycle k+209 and done in cycle k+210.
REQ-019 C_we and C_do SHALL be 0 at all times.
REQ-020 C_addr SHALL hold its last value outside FETCH.

Reset
REQ-021 rst_b=0 SHALL asynchronously force IDLE, w=0, j=0, buffer=0, C_addr=0, and out_valid, out_last, busy, done, out_data all 0.
REQ-022 Reset asserted mid-stream SHALL abandon the transfer; the next start SHALL restart from coefficient 0.

Verification
REQ-023 Full stream: memory word w slot j preset to 5w+j+1, out_ready=1 -> values 1..149 in order; first out_valid at k+3; out_last with value 149; done at k+210 only.
REQ-024 Backpressure: out_ready=0 for 11 cycles mid-word -> out_data held, no loss or duplication, done delayed to k+221.
REQ-025 Partial word: word 29 slot 4 preset to all-ones -> never emitted; exactly 149 transfers.
REQ-026 Start while busy: pulse start at k+50 -> no restart, stream identical to REQ-023.
REQ-027 Reset mid-stream: rst_b low at k+100 -> all outputs 0 immediately; a new start yields coefficients from 1 again.
REQ-028 Parameter variant n=10, d=5, m=83 -> 10 transfers from 2 full words; out_last on the 10th; done 15 cycles after start sampled.
